// File: rtl/fmu_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined FMU among NUM_REQ requesters.
// Optional macro FMU_ARB_PRIO_EN gives requester 0 strict priority over the round-robin.
module fmu_issue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OP_W    = 32,
  parameter int unsigned LAT     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    fmu_start,
  output logic [OP_W-1:0]         fmu_a,
  output logic [OP_W-1:0]         fmu_b,
  input  logic                    fmu_done,
  input  logic [OP_W-1:0]         fmu_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [OP_W-1:0]         rsp_data,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef FMU_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  logic [ID_W-1:0]    r_ptr;
  logic               r_start;
  logic [ID_W-1:0]    r_iss_id;
  logic [OP_W-1:0]    r_a;
  logic [OP_W-1:0]    r_b;
  logic [LAT:1]       r_tag_v;
  logic [ID_W-1:0]    r_tag_id [1:LAT];
  logic [NUM_REQ-1:0] r_rsp_v;
  logic [OP_W-1:0]    r_rsp_d;
  logic               r_err;

  logic               w_gnt_vld;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               w_tag_v;
  logic [ID_W-1:0]    w_tag_id;

  // First valid requester at or after the pointer; requester 0 may pre-empt.
  always_comb begin
    logic [ID_W-1:0] idx;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_gnt_vld && req_valid[idx] && !(PRIO_EN && idx == '0)) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = idx;
      end
    end
    if (PRIO_EN && req_valid[0]) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = '0;
    end
    if (!rst_n) begin
      w_gnt_vld = 1'b0;
    end
  end

  always_comb begin
    w_ptr_nxt = ID_W'((32'(w_gnt_id) + 32'd1) % NUM_REQ);
    if (PRIO_EN && w_gnt_id == '0) begin
      w_ptr_nxt = r_ptr;
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_gnt_vld) begin
      req_ready[w_gnt_id] = 1'b1;
    end
  end

  // Issue stage; operands hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_start  <= 1'b0;
      r_iss_id <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      r_start <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_iss_id <= w_gnt_id;
        r_a      <= req_a[w_gnt_id*OP_W +: OP_W];
        r_b      <= req_b[w_gnt_id*OP_W +: OP_W];
        r_ptr    <= w_ptr_nxt;
      end
    end
  end

  // Issue register acts as stage 0; stage LAT lines up with fmu_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      for (int unsigned k = 1; k <= LAT; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_v[1]  <= r_start;
      r_tag_id[1] <= r_iss_id;
      for (int unsigned k = 2; k <= LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  assign w_tag_v  = r_tag_v[LAT];
  assign w_tag_id = r_tag_id[LAT];

  // Response steering; a done/tag disagreement is suppressed and latched as err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_v <= '0;
      r_rsp_d <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rsp_v <= '0;
      if (fmu_done && w_tag_v) begin
        r_rsp_v <= NUM_REQ'(1) << w_tag_id;
        r_rsp_d <= fmu_result;
      end
      if (fmu_done != w_tag_v) begin
        r_err <= 1'b1;
      end
    end
  end

  assign fmu_start = r_start;
  assign fmu_a     = r_a;
  assign fmu_b     = r_b;
  assign rsp_valid = r_rsp_v;
  assign rsp_data  = r_rsp_d;
  assign err       = r_err;
  assign busy      = r_start | (|r_tag_v) | (|r_rsp_v);

endmodule

// File: doc/fmu_issue_arbiter.md
Name: fmu_issue_arbiter

Overview:
- Shares one pipelined floating-point multiply unit (FMU datapath plus its stage controller) between NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle into the FMU.
- Tracks the requester ID of each in-flight operation in a tag pipeline of depth LAT, and steers each result back to its owner.
- Sits between the requesting engines and the FMU's start/operand/done/result interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- OP_W, 32, operand and result width.
- LAT, 4, cycles from the cycle fmu_start is high to the cycle fmu_done is high (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_a  in  NUM_REQ*OP_W  operand A; requester i occupies bits [i*OP_W +: OP_W].
- req_b  in  NUM_REQ*OP_W  operand B; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; combinational from req_valid and the round-robin pointer.
- fmu_start  out  1  issue strobe to the FMU controller start input.
- fmu_a  out  OP_W  operand A to the FMU.
- fmu_b  out  OP_W  operand B to the FMU.
- fmu_done  in  1  completion strobe from the FMU controller.
- fmu_result  in  OP_W  FMU result, valid while fmu_done is high.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  OP_W  response data.
- busy  out  1  any operation in flight or pending response.
- err  out  1  sticky tag/done mismatch flag.

Behaviour:
- Reset (async, rst_n=0):
  - fmu_start=0, fmu_a=0, fmu_b=0, rsp_valid=0, rsp_data=0, err=0, busy=0.
  - RR pointer=0; all tag-pipeline valid bits cleared.
  - In-flight results are discarded. fmu_done pulses arriving after reset release with no valid tag set err.
- Arbitration:
  - Search starts at the pointer and proceeds i = ptr, ptr+1, ... modulo NUM_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1.
  - req_ready is all-zero when there are no requests or during reset.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - The requester must hold valid and operands stable until the transfer occurs.
  - No back-pressure from the FMU; one issue per cycle is sustained indefinitely.
- Issue stage (registered):
  - On a transfer, the next cycle has fmu_start=1, fmu_a/fmu_b = the granted operands, and tag stage 0 = {1, i}.
  - With no transfer, the next cycle has fmu_start=0; fmu_a/fmu_b hold their previous values.
  - The pointer advances to (i+1) mod NUM_REQ after a transfer; otherwise it is unchanged.
- Tag pipeline:
  - LAT-stage shift register of {valid, id[clog2(NUM_REQ)-1:0]}, advancing every cycle.
  - The stage-LAT output aligns with fmu_done.
- Response (registered):
  - If fmu_done=1 and the tag is valid, the next cycle has rsp_valid = onehot(id) and rsp_data = fmu_result.
  - Otherwise rsp_valid=0 and rsp_data holds its previous value.
  - Total latency from request handshake edge to rsp_valid is LAT+2 cycles.
  - Responses are never back-pressured.
- Error:
  - err is set on (fmu_done & ~tag_valid) or (tag_valid & ~fmu_done) at the tag output.
  - Sticky until reset; the response for a mismatching slot is suppressed.
- busy = fmu_start | any tag valid | any rsp_valid.
- Simultaneous events:
  - An issue and a response in the same cycle are independent.
  - A requester may be granted in the same cycle its previous response returns.
- Pointer wrap: after granting NUM_REQ-1 the pointer returns to 0.

Optional Feature:
- Macro: FMU_ARB_PRIO_EN.
- Defined: requester 0 has strict priority. If req_valid[0]=1, it is granted regardless of the pointer, and the pointer does not advance on a requester-0 grant. The remaining requesters are round-robin among themselves.
- Undefined: pure round-robin across all NUM_REQ requesters, as specified above.

Test Plan:
- Single requester 2 with a=0x3FC00000, b=0x40000000, FMU model returning 0x40400000 → req_ready=0100 the same cycle; fmu_start one cycle later; rsp_valid=0100 with rsp_data=0x40400000 LAT+2=6 cycles after the handshake; busy falls the cycle after.
- All four req_valid held high for 8 cycles → grants 0,1,2,3,0,1,2,3 on consecutive cycles; fmu_start high for 8 consecutive cycles; responses return in the same order, each with the correct id.
- Pointer at 2, requests only from 0 and 1 → grant 0 then 1; pointer ends at 2.
- Reset asserted mid-flight with 3 operations issued → outputs clear immediately; no rsp_valid after release; the model's late fmu_done pulses set err=1.
- Model drops one fmu_done → err=1 and stays 1; later correct operations still respond normally.
- With FMU_ARB_PRIO_EN and all four requesting continuously → only requester 0 is granted. Deassert req 0 → grants resume 1,2,3,1...
